// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared states and AXI constants for the DMA write engine
package dmac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] STRB_ALL   = 4'hF;

endpackage

// File: rtl/dmac_wr_engine.sv
// rtl/dmac_wr_engine.sv - AXI write engine draining a source FIFO into INCR bursts
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   start_i, dst_addr_i, byte_len_i transfer launch (sampled in IDLE only)
//   done_o, error_o                 completion pulse, sticky bad-response flag
//   fifo_empty_i/rden_o/rdata_i     external source FIFO (show-ahead head data)
//   aw*                             AXI write address channel
//   w*                              AXI write data channel
//   bresp_i, bvalid_i, bready_o     AXI write response channel
module dmac_wr_engine
    import dmac_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [31:0]           dst_addr_i,
    input  logic [15:0]           byte_len_i,
    output logic                  done_o,
    output logic                  error_o,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rden_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic [31:0]           awaddr_o,
    output logic [3:0]            awlen_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    output logic [3:0]            wstrb_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_BURST - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] addr;
    logic [15:0] rem;
    logic [3:0]  wcnt;
    logic [3:0]  awlen_q;
    logic        done_q;
    logic        error_q;

    logic [3:0]  burst_len;
    logic [4:0]  beats;
    logic [15:0] rem_after;

    // rem never changes while in AW, so awlen_o is stable during an AW stall.
    always_comb begin
        burst_len = MAX_LEN;
        if (rem < 16'(MAX_BURST)) begin
            burst_len = 4'(rem - 16'd1);
        end
    end

    assign beats     = {1'b0, awlen_q} + 5'd1;
    assign rem_after = rem - {11'd0, beats};

    assign awaddr_o  = addr;
    assign awlen_o   = awvalid_o ? burst_len : 4'd0;
    assign awsize_o  = SIZE_4B;
    assign awburst_o = BURST_INCR;
    assign wstrb_o   = STRB_ALL;
    assign wdata_o   = fifo_rdata_i;
    assign done_o    = done_q;
    assign error_o   = error_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        wlast_o     = 1'b0;
        fifo_rden_o = 1'b0;
        bready_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A zero-length start completes from IDLE without bus traffic.
                if (start_i && (byte_len_i != 16'd0)) begin
                    state_next = ST_AW;
                end
            end
            ST_AW: begin
                awvalid_o = 1'b1;
                if (awready_i) begin
                    state_next = ST_W;
                end
            end
            ST_W: begin
                wvalid_o    = !fifo_empty_i;
                wlast_o     = (wcnt == 4'd0);
                // Pop exactly on the handshake so the FIFO head feeds the next beat.
                fifo_rden_o = wvalid_o && wready_i;
                if (fifo_rden_o && wlast_o) begin
                    state_next = ST_B;
                end
            end
            ST_B: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    state_next = (rem_after != 16'd0) ? ST_AW : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr    <= 32'd0;
            rem     <= 16'd0;
            wcnt    <= 4'd0;
            awlen_q <= 4'd0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        addr    <= dst_addr_i;
                        rem     <= byte_len_i >> 2;
                        error_q <= 1'b0;
                        if (byte_len_i == 16'd0) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_AW: begin
                    if (awready_i) begin
                        wcnt    <= burst_len;
                        awlen_q <= burst_len;
                    end
                end
                ST_W: begin
                    if (fifo_rden_o) begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ST_B: begin
                    if (bvalid_i) begin
                        if (bresp_i != RESP_OKAY) begin
                            error_q <= 1'b1;
                        end
                        addr <= addr + {25'd0, beats, 2'b00};
                        rem  <= rem_after;
                        if (rem_after == 16'd0) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
